// File: rtl/coh_pkg.sv
// Shared types and the MESI outcome decode for the snooping coherence
// controller.
//   mesi_t    : per-core, per-line cache state
//   fsm_t     : controller phase (also exported on the debug output)
//   oth_act_t : action applied to every non-requesting core's copy
//   outcome_t : decoded result of one snoop
//   coh_decode: maps (requester state, wr, other-M, other-valid) to outcome_t
package coh_pkg;

  typedef enum logic [1:0] {
    MESI_I = 2'd0,
    MESI_S = 2'd1,
    MESI_E = 2'd2,
    MESI_M = 2'd3
  } mesi_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SNOOP = 2'd1,
    ST_MEM   = 2'd2,
    ST_DONE  = 2'd3
  } fsm_t;

  typedef enum logic [1:0] {
    OTH_KEEP = 2'd0,  // other copies untouched
    OTH_TO_S = 2'd1,  // every valid other copy drops to S
    OTH_TO_I = 2'd2   // every other copy is invalidated
  } oth_act_t;

  typedef struct packed {
    mesi_t    req_next;
    oth_act_t oth;
    logic     fetch;
    logic     wb;
  } outcome_t;

  // The other cores are summarised by two flags, so the decode does not
  // depend on the core count.
  function automatic outcome_t coh_decode(input mesi_t req_st,
                                          input logic  wr,
                                          input logic  oth_m,
                                          input logic  oth_v);
    outcome_t o;
    o.req_next = req_st;
    o.oth      = OTH_KEEP;
    o.fetch    = 1'b0;
    o.wb       = 1'b0;
    if (wr) begin
      o.req_next = MESI_M;
      o.oth      = OTH_TO_I;
      o.wb       = oth_m;
      o.fetch    = (req_st == MESI_I) && !oth_v;
    end else if (req_st == MESI_I) begin
      if (oth_v) begin
        // Some cache supplies the line; an M holder also flushes it.
        o.req_next = MESI_S;
        o.oth      = OTH_TO_S;
        o.wb       = oth_m;
      end else begin
        o.req_next = MESI_E;
        o.fetch    = 1'b1;
      end
    end
    return o;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
//   req_i  : per-core request vector
//   last_i : ID of the previous winner; search starts at last_i+1
//   gnt_o  : one-hot grant (all zero when no request)
//   id_o   : encoded ID of the granted core
module rr_arbiter #(
  parameter int NUM_CORES = 4,
  parameter int CID_W     = $clog2(NUM_CORES)
) (
  input  logic [NUM_CORES-1:0] req_i,
  input  logic [CID_W-1:0]     last_i,
  output logic [NUM_CORES-1:0] gnt_o,
  output logic [CID_W-1:0]     id_o
);

  int   idx;
  logic found;

  always_comb begin
    gnt_o = '0;
    id_o  = '0;
    idx   = 0;
    found = 1'b0;
    // i == NUM_CORES wraps back to last_i, so the previous winner is
    // considered last.
    for (int i = 1; i <= NUM_CORES; i++) begin
      idx = (int'(last_i) + i) % NUM_CORES;
      if (!found && req_i[idx]) begin
        found      = 1'b1;
        gnt_o[idx] = 1'b1;
        id_o       = CID_W'(idx);
      end
    end
  end

endmodule

// File: rtl/mesi_snoop_ctrl.sv
// Snooping MESI coherence controller for NUM_CORES caches and 2**ADDR_W lines.
//   req_valid/req_wr/req_addr : per-core line requests
//   gnt                       : one-hot grant pulse (SNOOP cycle)
//   resp_valid/core/state     : completion pulse with requester's new state
//   mem_rd                    : high for each of the MEM_LAT fetch cycles
//   wb_valid/wb_core          : pulse when an M copy was flushed
//   q_core/q_addr/q_state     : combinational debug read of the state array
//   dbg_state                 : current controller phase
//
// Handshake: a core holds req_valid (with stable req_wr/req_addr) until it
// sees its gnt bit. The request is captured when gnt is issued, so a
// req_valid still high after gnt is a new request.
module mesi_snoop_ctrl
  import coh_pkg::*;
#(
  parameter int NUM_CORES = 4,
  parameter int ADDR_W    = 4,
  parameter int MEM_LAT   = 2,
  parameter int CID_W     = $clog2(NUM_CORES)
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [NUM_CORES-1:0]             req_valid,
  input  logic [NUM_CORES-1:0]             req_wr,
  input  logic [NUM_CORES-1:0][ADDR_W-1:0] req_addr,
  output logic [NUM_CORES-1:0]             gnt,
  output logic                             resp_valid,
  output logic [CID_W-1:0]                 resp_core,
  output logic [1:0]                       resp_state,
  output logic                             mem_rd,
  output logic                             wb_valid,
  output logic [CID_W-1:0]                 wb_core,
  input  logic [CID_W-1:0]                 q_core,
  input  logic [ADDR_W-1:0]                q_addr,
  output logic [1:0]                       q_state,
  output fsm_t                             dbg_state
);

  localparam int LINES = 1 << ADDR_W;
  localparam int CNT_W = $clog2(MEM_LAT + 1);

  fsm_t                 state_q, state_d;
  logic [CID_W-1:0]     last_q, last_d;
  logic [CID_W-1:0]     win_q, win_d;
  logic                 wr_q, wr_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  outcome_t             oc_q, oc_d;
  logic [CID_W-1:0]     mcore_q, mcore_d;
  logic [NUM_CORES-1:0] gnt_q, gnt_d;
  logic                 resp_valid_q, resp_valid_d;
  logic [CID_W-1:0]     resp_core_q, resp_core_d;
  mesi_t                resp_state_q, resp_state_d;
  logic                 mem_rd_q, mem_rd_d;
  logic                 wb_valid_q, wb_valid_d;
  logic [CID_W-1:0]     wb_core_q, wb_core_d;
  logic                 commit;

  mesi_t st_q [NUM_CORES][LINES];

  logic [NUM_CORES-1:0] arb_gnt;
  logic [CID_W-1:0]     arb_id;

  rr_arbiter #(
    .NUM_CORES (NUM_CORES),
    .CID_W     (CID_W)
  ) u_arb (
    .req_i  (req_valid),
    .last_i (last_q),
    .gnt_o  (arb_gnt),
    .id_o   (arb_id)
  );

  // Snoop of the captured line across all cores.
  mesi_t            req_st;
  logic             oth_m, oth_v;
  logic [CID_W-1:0] m_core;
  outcome_t         snoop_oc;

  always_comb begin
    req_st = st_q[win_q][addr_q];
    oth_m  = 1'b0;
    oth_v  = 1'b0;
    m_core = '0;
    for (int c = 0; c < NUM_CORES; c++) begin
      if (CID_W'(c) != win_q) begin
        if (st_q[c][addr_q] != MESI_I) oth_v = 1'b1;
        if (st_q[c][addr_q] == MESI_M) begin
          oth_m  = 1'b1;
          m_core = CID_W'(c);
        end
      end
    end
    snoop_oc = coh_decode(req_st, wr_q, oth_m, oth_v);
  end

  // Next-state and output logic.
  always_comb begin
    state_d      = state_q;
    last_d       = last_q;
    win_d        = win_q;
    wr_d         = wr_q;
    addr_d       = addr_q;
    cnt_d        = cnt_q;
    oc_d         = oc_q;
    mcore_d      = mcore_q;
    gnt_d        = '0;
    resp_valid_d = 1'b0;
    resp_core_d  = resp_core_q;
    resp_state_d = resp_state_q;
    mem_rd_d     = 1'b0;
    wb_valid_d   = 1'b0;
    wb_core_d    = wb_core_q;
    commit       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (|req_valid) begin
          state_d = ST_SNOOP;
          gnt_d   = arb_gnt;
          win_d   = arb_id;
          wr_d    = req_wr[arb_id];
          addr_d  = req_addr[arb_id];
        end
      end
      ST_SNOOP: begin
        oc_d    = snoop_oc;
        mcore_d = m_core;
        if (snoop_oc.fetch) begin
          state_d  = ST_MEM;
          cnt_d    = CNT_W'(MEM_LAT);
          mem_rd_d = 1'b1;
        end else begin
          state_d      = ST_DONE;
          resp_valid_d = 1'b1;
          resp_core_d  = win_q;
          resp_state_d = snoop_oc.req_next;
          wb_valid_d   = snoop_oc.wb;
          if (snoop_oc.wb) wb_core_d = m_core;
        end
      end
      ST_MEM: begin
        // mem_rd is registered, so it is raised one state ahead and the
        // last fetch cycle launches the DONE pulses instead.
        if (cnt_q == CNT_W'(1)) begin
          state_d      = ST_DONE;
          resp_valid_d = 1'b1;
          resp_core_d  = win_q;
          resp_state_d = oc_q.req_next;
          wb_valid_d   = oc_q.wb;
          if (oc_q.wb) wb_core_d = mcore_q;
        end else begin
          cnt_d    = cnt_q - CNT_W'(1);
          mem_rd_d = 1'b1;
        end
      end
      ST_DONE: begin
        commit  = 1'b1;
        last_d  = win_q;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      last_q       <= CID_W'(NUM_CORES - 1);
      win_q        <= '0;
      wr_q         <= 1'b0;
      addr_q       <= '0;
      cnt_q        <= '0;
      oc_q         <= '0;
      mcore_q      <= '0;
      gnt_q        <= '0;
      resp_valid_q <= 1'b0;
      resp_core_q  <= '0;
      resp_state_q <= MESI_I;
      mem_rd_q     <= 1'b0;
      wb_valid_q   <= 1'b0;
      wb_core_q    <= '0;
    end else begin
      state_q      <= state_d;
      last_q       <= last_d;
      win_q        <= win_d;
      wr_q         <= wr_d;
      addr_q       <= addr_d;
      cnt_q        <= cnt_d;
      oc_q         <= oc_d;
      mcore_q      <= mcore_d;
      gnt_q        <= gnt_d;
      resp_valid_q <= resp_valid_d;
      resp_core_q  <= resp_core_d;
      resp_state_q <= resp_state_d;
      mem_rd_q     <= mem_rd_d;
      wb_valid_q   <= wb_valid_d;
      wb_core_q    <= wb_core_d;
    end
  end

  // State array: the whole transaction commits at the end of DONE, so an
  // aborted transaction leaves nothing behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < NUM_CORES; c++) begin
        for (int l = 0; l < LINES; l++) begin
          st_q[c][l] <= MESI_I;
        end
      end
    end else if (commit) begin
      for (int c = 0; c < NUM_CORES; c++) begin
        if (CID_W'(c) == win_q) begin
          st_q[c][addr_q] <= oc_q.req_next;
        end else if (oc_q.oth == OTH_TO_I) begin
          st_q[c][addr_q] <= MESI_I;
        end else if (oc_q.oth == OTH_TO_S && st_q[c][addr_q] != MESI_I) begin
          st_q[c][addr_q] <= MESI_S;
        end
      end
    end
  end

  always_comb begin
    q_state = MESI_I;
    if (int'(q_core) < NUM_CORES) q_state = st_q[q_core][q_addr];
  end

  assign gnt        = gnt_q;
  assign resp_valid = resp_valid_q;
  assign resp_core  = resp_core_q;
  assign resp_state = resp_state_q;
  assign mem_rd     = mem_rd_q;
  assign wb_valid   = wb_valid_q;
  assign wb_core    = wb_core_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_mesi_snoop_ctrl.sv
// Bench for mesi_snoop_ctrl: table-driven directed transactions, hand-written
// arbitration and mid-fetch reset sequences, then random transactions checked
// against a line-level MESI reference model.
module tb_mesi_snoop_ctrl;
  import coh_pkg::*;

  localparam int NUM_CORES = 4;
  localparam int ADDR_W    = 4;
  localparam int MEM_LAT   = 2;
  localparam int CID_W     = 2;
  localparam int LINES     = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [NUM_CORES-1:0]             req_valid;
  logic [NUM_CORES-1:0]             req_wr;
  logic [NUM_CORES-1:0][ADDR_W-1:0] req_addr;
  logic [NUM_CORES-1:0]             gnt;
  logic                             resp_valid;
  logic [CID_W-1:0]                 resp_core;
  logic [1:0]                       resp_state;
  logic                             mem_rd;
  logic                             wb_valid;
  logic [CID_W-1:0]                 wb_core;
  logic [CID_W-1:0]                 q_core;
  logic [ADDR_W-1:0]                q_addr;
  logic [1:0]                       q_state;
  fsm_t                             dbg_state;

  mesi_snoop_ctrl #(
    .NUM_CORES (NUM_CORES),
    .ADDR_W    (ADDR_W),
    .MEM_LAT   (MEM_LAT)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_wr     (req_wr),
    .req_addr   (req_addr),
    .gnt        (gnt),
    .resp_valid (resp_valid),
    .resp_core  (resp_core),
    .resp_state (resp_state),
    .mem_rd     (mem_rd),
    .wb_valid   (wb_valid),
    .wb_core    (wb_core),
    .q_core     (q_core),
    .q_addr     (q_addr),
    .q_state    (q_state),
    .dbg_state  (dbg_state)
  );

  // ---------------- scoreboard counters ----------------
  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // States as integers: 0=I 1=S 2=E 3=M.
  int ref_st [NUM_CORES][LINES];

  task automatic model_clear();
    for (int c = 0; c < NUM_CORES; c++)
      for (int l = 0; l < LINES; l++) ref_st[c][l] = 0;
  endtask

  task automatic model_txn(input int core, input int wr, input int addr,
                           output int e_state, output int e_fetch,
                           output int e_wb, output int e_wbcore);
    int others_valid;
    int m_holder;
    others_valid = 0;
    m_holder     = -1;
    for (int c = 0; c < NUM_CORES; c++) begin
      if (c != core) begin
        if (ref_st[c][addr] != 0) others_valid++;
        if (ref_st[c][addr] == 3) m_holder = c;
      end
    end
    e_fetch  = 0;
    e_wb     = (m_holder >= 0) ? 1 : 0;
    e_wbcore = (m_holder >= 0) ? m_holder : 0;
    if (wr != 0) begin
      e_fetch = (ref_st[core][addr] == 0 && others_valid == 0) ? 1 : 0;
      for (int c = 0; c < NUM_CORES; c++) ref_st[c][addr] = 0;
      ref_st[core][addr] = 3;
    end else if (ref_st[core][addr] != 0) begin
      e_wb = 0;
    end else if (others_valid > 0) begin
      for (int c = 0; c < NUM_CORES; c++)
        if (ref_st[c][addr] != 0) ref_st[c][addr] = 1;
      ref_st[core][addr] = 1;
    end else begin
      ref_st[core][addr] = 2;
      e_fetch = 1;
    end
    e_state = ref_st[core][addr];
  endtask

  // ---------------- driver tasks ----------------
  task automatic query(input int c, input int a, output int s);
    q_core = CID_W'(c);
    q_addr = ADDR_W'(a);
    #1;
    s = int'(q_state);
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    req_valid = '0;
    req_wr    = '0;
    req_addr  = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_clear();
  endtask

  // One transaction from an idle controller; expected values come from the
  // caller, line states after commit are checked against ref_st.
  task automatic do_txn(input int core, input int wr, input int addr,
                        input int e_state, input int e_fetch, input int e_wb,
                        input int e_wbcore, input string tag);
    int cyc, gnt_cyc, resp_cyc, mem_cnt, wb_seen, wb_c, r_core, r_state, gnt_val;
    int s, owners, valids;
    cyc = 0; gnt_cyc = -1; resp_cyc = -1; mem_cnt = 0; wb_seen = 0; wb_c = 0;
    r_core = -1; r_state = -1; gnt_val = 0;
    @(negedge clk);
    req_valid[core] = 1'b1;
    req_wr[core]    = (wr != 0);
    req_addr[core]  = ADDR_W'(addr);
    while (resp_cyc < 0 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (gnt != '0 && gnt_cyc < 0) begin
        gnt_cyc = cyc;
        gnt_val = int'(gnt);
        req_valid[core] = 1'b0;
      end
      if (mem_rd) mem_cnt++;
      if (wb_valid) begin
        wb_seen++;
        wb_c = int'(wb_core);
      end
      if (resp_valid) begin
        resp_cyc = cyc;
        r_core   = int'(resp_core);
        r_state  = int'(resp_state);
      end
    end
    req_valid[core] = 1'b0;
    check({tag, ".gnt"}, gnt_val, 1 << core);
    check({tag, ".gnt_cyc"}, gnt_cyc, 1);
    check({tag, ".resp_cyc"}, resp_cyc, 2 + ((e_fetch != 0) ? MEM_LAT : 0));
    check({tag, ".resp_core"}, r_core, core);
    check({tag, ".resp_state"}, r_state, e_state);
    check({tag, ".mem_rd_cycles"}, mem_cnt, (e_fetch != 0) ? MEM_LAT : 0);
    check({tag, ".wb_valid"}, wb_seen, e_wb);
    if (e_wb != 0) check({tag, ".wb_core"}, wb_c, e_wbcore);
    @(negedge clk);
    owners = 0;
    valids = 0;
    for (int c = 0; c < NUM_CORES; c++) begin
      query(c, addr, s);
      check($sformatf("%s.q_state[%0d]", tag, c), s, ref_st[c][addr]);
      if (s >= 2) owners++;
      if (s != 0) valids++;
    end
    check({tag, ".single_owner"}, (owners == 0 || valids == 1) ? 1 : 0, 1);
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    int core;
    int wr;
    int addr;
    int e_state;
    int e_fetch;
    int e_wb;
    int e_wbcore;
    int e_line [NUM_CORES];
  } vec_t;

  localparam int NVEC = 12;
  vec_t vecs [NVEC];

  task automatic set_vec(input int i, input int core, input int wr, input int addr,
                         input int st, input int f, input int wb, input int wbc,
                         input int l0, input int l1, input int l2, input int l3);
    vecs[i].core      = core;
    vecs[i].wr        = wr;
    vecs[i].addr      = addr;
    vecs[i].e_state   = st;
    vecs[i].e_fetch   = f;
    vecs[i].e_wb      = wb;
    vecs[i].e_wbcore  = wbc;
    vecs[i].e_line[0] = l0;
    vecs[i].e_line[1] = l1;
    vecs[i].e_line[2] = l2;
    vecs[i].e_line[3] = l3;
  endtask

  int ms, mf, mw, mwc, s_tmp, cyc, n_g, n_r, seen, cnt, non_i;
  int g_who [4];
  int g_cyc [4];
  int r_st  [4];
  int exp_gc [4];
  int exp_rs [4];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    //            i  core wr addr st f wb wbc  line
    set_vec(0,  0, 0, 3, 2, 1, 0, 0,  2, 0, 0, 0);
    set_vec(1,  1, 0, 3, 1, 0, 0, 0,  1, 1, 0, 0);
    set_vec(2,  2, 1, 3, 3, 0, 0, 0,  0, 0, 3, 0);
    set_vec(3,  3, 0, 3, 1, 0, 1, 2,  0, 0, 1, 1);
    set_vec(4,  0, 1, 3, 3, 0, 0, 0,  3, 0, 0, 0);
    set_vec(5,  0, 0, 3, 3, 0, 0, 0,  3, 0, 0, 0);
    set_vec(6,  1, 1, 5, 3, 1, 0, 0,  0, 3, 0, 0);
    set_vec(7,  2, 1, 5, 3, 0, 1, 1,  0, 0, 3, 0);
    set_vec(8,  2, 0, 5, 3, 0, 0, 0,  0, 0, 3, 0);
    set_vec(9,  3, 1, 3, 3, 0, 1, 0,  0, 0, 0, 3);
    set_vec(10, 0, 0, 8, 2, 1, 0, 0,  2, 0, 0, 0);
    set_vec(11, 0, 1, 8, 3, 0, 0, 0,  3, 0, 0, 0);

    q_core = '0;
    q_addr = '0;
    do_reset();

    // Reset state.
    @(negedge clk);
    check("reset.gnt", int'(gnt), 0);
    check("reset.resp_valid", int'(resp_valid), 0);
    check("reset.mem_rd", int'(mem_rd), 0);
    check("reset.wb_valid", int'(wb_valid), 0);
    check("reset.resp_core", int'(resp_core), 0);
    check("reset.resp_state", int'(resp_state), 0);
    check("reset.wb_core", int'(wb_core), 0);
    check("reset.fsm_idle", int'(dbg_state), int'(ST_IDLE));
    query(3, 3, s_tmp);
    check("reset.q_state", s_tmp, 0);

    // Directed table.
    for (int i = 0; i < NVEC; i++) begin
      model_txn(vecs[i].core, vecs[i].wr, vecs[i].addr, ms, mf, mw, mwc);
      do_txn(vecs[i].core, vecs[i].wr, vecs[i].addr, vecs[i].e_state,
             vecs[i].e_fetch, vecs[i].e_wb, vecs[i].e_wbcore, $sformatf("t%0d", i));
      for (int c = 0; c < NUM_CORES; c++) begin
        query(c, vecs[i].addr, s_tmp);
        check($sformatf("t%0d.line[%0d]", i, c), s_tmp, vecs[i].e_line[c]);
      end
    end

    // All four cores request together right after reset; round-robin order
    // 0,1,2,3. Core 0 fetches (line 7 is I everywhere), the rest share.
    do_reset();
    @(negedge clk);
    req_wr = '0;
    for (int c = 0; c < NUM_CORES; c++) req_addr[c] = ADDR_W'(7);
    req_valid = '1;
    n_g = 0; n_r = 0; cyc = 0;
    while ((n_g < 4 || n_r < 4) && cyc < 80) begin
      @(negedge clk);
      cyc++;
      if (gnt != '0 && n_g < 4) begin
        check($sformatf("rr.onehot%0d", n_g), $countones(gnt), 1);
        g_who[n_g] = -1;
        for (int c = NUM_CORES - 1; c >= 0; c--) if (gnt[c]) g_who[n_g] = c;
        g_cyc[n_g] = cyc;
        n_g++;
        req_valid = req_valid & ~gnt;
      end
      if (resp_valid && n_r < 4) begin
        r_st[n_r] = int'(resp_state);
        n_r++;
      end
    end
    req_valid = '0;
    check("rr.grants", n_g, 4);
    check("rr.resps", n_r, 4);
    exp_gc[0] = 1;
    exp_gc[1] = 4 + MEM_LAT;
    exp_gc[2] = 7 + MEM_LAT;
    exp_gc[3] = 10 + MEM_LAT;
    for (int i = 0; i < 4; i++) begin
      model_txn(i, 0, 7, ms, mf, mw, mwc);
      exp_rs[i] = ms;
    end
    for (int i = 0; i < n_g; i++) begin
      check($sformatf("rr.who%0d", i), g_who[i], i);
      check($sformatf("rr.cyc%0d", i), g_cyc[i], exp_gc[i]);
    end
    for (int i = 0; i < n_r; i++) check($sformatf("rr.state%0d", i), r_st[i], exp_rs[i]);
    @(negedge clk);
    for (int c = 0; c < NUM_CORES; c++) begin
      query(c, 7, s_tmp);
      check($sformatf("rr.q_state[%0d]", c), s_tmp, 1);
    end

    // Reset while fetching: outputs drop at once, nothing commits.
    @(negedge clk);
    req_valid[2] = 1'b1;
    req_wr[2]    = 1'b0;
    req_addr[2]  = ADDR_W'(9);
    seen = 0; cyc = 0;
    while (seen == 0 && cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (gnt[2]) req_valid[2] = 1'b0;
      if (mem_rd) seen = 1;
    end
    check("abort.mem_rd_seen", seen, 1);
    rst_n = 1'b0;
    #1;
    check("abort.mem_rd", int'(mem_rd), 0);
    check("abort.gnt", int'(gnt), 0);
    check("abort.resp_valid", int'(resp_valid), 0);
    check("abort.wb_valid", int'(wb_valid), 0);
    check("abort.resp_core", int'(resp_core), 0);
    check("abort.resp_state", int'(resp_state), 0);
    check("abort.wb_core", int'(wb_core), 0);
    req_valid = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_clear();
    cnt = 0;
    repeat (10) begin
      @(negedge clk);
      if (resp_valid) cnt++;
    end
    check("abort.no_resp", cnt, 0);
    non_i = 0;
    for (int c = 0; c < NUM_CORES; c++)
      for (int l = 0; l < LINES; l++) begin
        query(c, l, s_tmp);
        if (s_tmp != 0) non_i++;
      end
    check("abort.all_invalid", non_i, 0);
    @(negedge clk);

    // Random transactions on a few lines to force sharing and ownership moves.
    for (int i = 0; i < 60; i++) begin
      int rc, rw, ra;
      rc = $urandom_range(0, NUM_CORES - 1);
      rw = $urandom_range(0, 1);
      ra = $urandom_range(0, 3);
      model_txn(rc, rw, ra, ms, mf, mw, mwc);
      do_txn(rc, rw, ra, ms, mf, mw, mwc, $sformatf("rnd%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
